ring_arbiter: RTL and testbench

RING_ARBITER -- requirements
Module: ring_arbiter

---
 rtl/ring_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ring_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_arbiter.sv
// ---------------------------------------------------------------------------
// ring_arbiter
//
// Four-way round-robin arbiter with a bounded grant length.
//
// While idle, the first active request is granted. The search starts at the
// rotating priority pointer and wraps from bit 3 back to bit 0. A grant is
// held while its owner keeps requesting, for at most MAX_HOLD consecutive
// cycles.
//
// On release the grant drops for one dead cycle, and the pointer moves to the
// requester just after the released owner. If the owner was still requesting
// when the grant hit its length limit, that release is forced and is flagged
// by a one-cycle timeout pulse.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   req       in   4  level request, bit i = requester i
//   grant     out  4  one-hot grant or zero (registered)
//   grant_id  out  2  index of granted requester, 0 when idle (registered)
//   busy      out  1  high whenever grant is non-zero (registered)
//   timeout   out  1  one-cycle pulse after a forced release (registered)
// ---------------------------------------------------------------------------
module ring_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  // Last legal value of the hold counter. A grant whose counter reaches this
  // value has been asserted for MAX_HOLD cycles.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     state_q;
  logic [3:0] ptr_q;
  logic [3:0] hold_cnt_q;
  logic [3:0] grant_q;
  logic [1:0] grant_id_q;
  logic       busy_q;
  logic       timeout_q;

  logic [1:0] pick_id_d;
  logic [3:0] pick_grant_d;
  logic [3:0] hold_cnt_d;
  logic [3:0] ptr_d;
  logic       owner_req_d;
  logic       hold_expired_d;

  // Convert the one-hot pointer to a binary index. An illegal pointer falls
  // back to index 0, which matches the reset position.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Round-robin pick. Candidates are visited from farthest to nearest
  // relative to base, so the nearest set bit is the last one written. The
  // 2-bit addition wraps naturally from 3 to 0.
  function automatic logic [1:0] rr_pick(input logic [1:0] base,
                                         input logic [3:0] r);
    logic [1:0] cand;
    logic [1:0] sel;
    sel = base;
    for (int i = 3; i >= 0; i--) begin
      cand = base + 2'(i);
      if (r[cand]) begin
        sel = cand;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Next-state helpers: the arbitration winner, the saturating hold count,
  // and the pointer position that follows the current owner.
  always_comb begin
    pick_id_d      = rr_pick(onehot_to_idx(ptr_q), req);
    pick_grant_d   = 4'b0001 << pick_id_d;
    owner_req_d    = req[grant_id_q];
    hold_expired_d = (hold_cnt_q >= HOLD_LAST);
    if (hold_cnt_q < HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + 4'd1;
    end else begin
      hold_cnt_d = HOLD_LAST;
    end
    ptr_d = 4'b0001 << (grant_id_q + 2'd1);
  end

  // Arbitration FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 4'b0001;
      hold_cnt_q <= 4'd0;
      grant_q    <= 4'b0000;
      grant_id_q <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timeout_q <= 1'b0;
          if (req != 4'b0000) begin
            state_q    <= ST_HOLD;
            grant_q    <= pick_grant_d;
            grant_id_q <= pick_id_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= 4'd0;
          end else begin
            state_q    <= ST_IDLE;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            hold_cnt_q <= 4'd0;
          end
        end
        ST_HOLD: begin
          if (!owner_req_d || hold_expired_d) begin
            // A release always leaves one dead cycle before the next grant.
            // The pointer passes the released owner, so a force-released
            // requester that is still requesting gets lowest priority.
            state_q    <= ST_IDLE;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            hold_cnt_q <= 4'd0;
            ptr_q      <= ptr_d;
            // The pulse is raised only when the owner still wanted the grant.
            timeout_q  <= owner_req_d;
          end else begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ptr_q      <= 4'b0001;
          hold_cnt_q <= 4'd0;
          grant_q    <= 4'b0000;
          grant_id_q <= 2'd0;
          busy_q     <= 1'b0;
          timeout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_arbiter
//
// Self-checking bench for ring_arbiter. A behavioural model tracks the
// current owner, how many cycles its grant has lasted, and the priority
// position, all as plain integers. Directed scenarios are followed by a long
// random run.
// ---------------------------------------------------------------------------
module tb_ring_arbiter;

  localparam int MAX_HOLD   = 8;
  localparam int FAIR_BOUND = 4 * (MAX_HOLD + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_owner = -1;  // -1 = no grant
  int m_held  = 0;   // cycles the current grant has been asserted
  int m_ptr   = 0;   // priority start position, 0..3
  bit m_to    = 1'b0;

  ring_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
  endtask

  // One clock of the arbitration rules, applied to the sampled request.
  task automatic model_step(input logic [3:0] r);
    if (m_owner < 0) begin
      m_to = 1'b0;
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_ptr + i) % 4;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_held  = 0;
      m_to    = 1'b0;
    end else if (m_held >= MAX_HOLD) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_held  = 0;
      m_to    = 1'b1;
    end else begin
      m_held = m_held + 1;
      m_to   = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] g;
    logic [1:0] id;
    if (m_owner < 0) begin
      g  = 4'b0000;
      id = 2'd0;
    end else begin
      g  = 4'b0001 << m_owner;
      id = 2'(m_owner);
    end
    return {g, id, (m_owner >= 0), m_to};
  endfunction

  // Apply a request at the falling edge, let one rising edge sample it,
  // advance the model, and return at the next falling edge.
  task automatic drive_cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req = 4'b0000;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async: got %b want 00000000",
               {grant, grant_id, busy, timeout});
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_held: got %b want 00000000",
               {grant, grant_id, busy, timeout});
    end
    rst = 1'b0;
    drive_cycle(4'b0000);
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL idle_no_req: got %b want 00000000",
               {grant, grant_id, busy, timeout});
    end
  endtask

  // All requesters active: five back-to-back forced rotations.
  task automatic test_rotation();
    apply_reset();
    for (int g = 0; g < 5; g++) begin
      logic [3:0] want;
      want = 4'b0001 << (g % 4);
      for (int k = 0; k < MAX_HOLD; k++) begin
        drive_cycle(4'b1111);
        n_cmp++;
        if ({grant, grant_id, busy, timeout} !== {want, 2'(g % 4), 1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL rotation_hold g=%0d k=%0d: got %b want %b", g, k,
                   {grant, grant_id, busy, timeout}, {want, 2'(g % 4), 1'b1, 1'b0});
        end
      end
      drive_cycle(4'b1111);
      n_cmp++;
      if ({grant, grant_id, busy, timeout} !== 8'b0000_00_0_1) begin
        n_err++;
        $display("FAIL rotation_dead g=%0d: got %b want 00000001", g,
                 {grant, grant_id, busy, timeout});
      end
    end
  endtask

  // Voluntary release after three cycles, followed by a wrapped pick.
  task automatic test_voluntary_and_wrap();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(4'b0100);
      n_cmp++;
      if ({grant, grant_id, busy, timeout} !== 8'b0100_10_1_0) begin
        n_err++;
        $display("FAIL voluntary_hold k=%0d: got %b want 01001010", k,
                 {grant, grant_id, busy, timeout});
      end
    end
    drive_cycle(4'b0000);
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL voluntary_release: got %b want 00000000",
               {grant, grant_id, busy, timeout});
    end
    drive_cycle(4'b0011);
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'b0001_00_1_0) begin
      n_err++;
      $display("FAIL wrap_pick: got %b want 00010010",
               {grant, grant_id, busy, timeout});
    end
  endtask

  // Other requesters toggle while requester 1 holds the grant.
  task automatic test_ignore_others();
    drive_cycle(4'b0000);
    for (int k = 0; k < MAX_HOLD; k++) begin
      logic [3:0] r;
      r = {1'($urandom_range(1)), 1'b0, 1'b1, 1'($urandom_range(1))};
      drive_cycle(r);
      n_cmp++;
      if ({grant, grant_id, busy, timeout} !== 8'b0010_01_1_0) begin
        n_err++;
        $display("FAIL ignore_others k=%0d req=%b: got %b want 00100110", k, r,
                 {grant, grant_id, busy, timeout});
      end
    end
    drive_cycle(4'b1011);
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'b0000_00_0_1) begin
      n_err++;
      $display("FAIL ignore_forced: got %b want 00000001",
               {grant, grant_id, busy, timeout});
    end
  endtask

  // Reset lands in the middle of a grant, with no clock edge involved.
  task automatic test_reset_mid_hold();
    drive_cycle(4'b0110);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(4'b0110);
    end
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== model_vec()) begin
      n_err++;
      $display("FAIL mid_hold_pre: got %b want %b",
               {grant, grant_id, busy, timeout}, model_vec());
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL mid_hold_async_reset: got %b want 00000000",
               {grant, grant_id, busy, timeout});
    end
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(4'b1000);
    n_cmp++;
    if ({grant, grant_id, busy, timeout} !== 8'b1000_11_1_0) begin
      n_err++;
      $display("FAIL after_reset_grant: got %b want 10001110",
               {grant, grant_id, busy, timeout});
    end
  endtask

  // Slowly changing random requests, checked against the model and against
  // the one-hot, hold-length and fairness properties.
  task automatic test_random();
    int run_len;
    int wait_cnt [4];
    logic [3:0] r;
    apply_reset();
    run_len = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    r = 4'b0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      drive_cycle(r);
      n_cmp++;
      if ({grant, grant_id, busy, timeout} !== model_vec()) begin
        n_err++;
        $display("FAIL rand_model cyc=%0d req=%b: got %b want %b", cyc, r,
                 {grant, grant_id, busy, timeout}, model_vec());
      end
      n_cmp++;
      if ($countones(grant) > 1 || busy !== (|grant)) begin
        n_err++;
        $display("FAIL rand_onehot_busy cyc=%0d: grant=%b busy=%b", cyc, grant, busy);
      end
      if (grant != 4'b0000) run_len++;
      else run_len = 0;
      n_cmp++;
      if (run_len > MAX_HOLD) begin
        n_err++;
        $display("FAIL rand_hold_len cyc=%0d: run=%0d max=%0d", cyc, run_len, MAX_HOLD);
      end
      for (int i = 0; i < 4; i++) begin
        if (r[i] && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
      end
      n_cmp++;
      if (wait_cnt[0] > FAIR_BOUND || wait_cnt[1] > FAIR_BOUND ||
          wait_cnt[2] > FAIR_BOUND || wait_cnt[3] > FAIR_BOUND) begin
        n_err++;
        $display("FAIL rand_fairness cyc=%0d: waits=%0d,%0d,%0d,%0d bound=%0d", cyc,
                 wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3], FAIR_BOUND);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_voluntary_and_wrap();
    test_ignore_others();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
